inst_fetch: RTL

Fetch stage directly upstream of the instruction decoder. Owns the program counter and requests 8-bit instructions from program memory over a req/ack handshake. Holds the fetched word in the instruction register (inst_reg), which drives the decoder's inst_reg input. Supports stall from downstream via valid/ready, and redirect on taken branch with squash of any in-flight fetch.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/inst_fetch_buf.sv | 42 ++++
 rtl/inst_fetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

    localparam int         DEF_PC_W   = 8;
    localparam int         DEF_INST_W = 8;
    localparam int         RESET_PC   = 0;
    localparam logic [7:0] NOP_INST   = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2,
        FULL   = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_buf.sv
`default_nettype none
// ============================================================================
// inst_fetch_buf : one-entry prefetch holding register (data, pc, valid)
// Revision       : 1.0
// ============================================================================
module inst_fetch_buf
    import fetch_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [INST_W-1:0] load_data,
    input  logic [PC_W-1:0]   load_pc,
    input  logic              clear,
    input  logic              consume,
    output logic [INST_W-1:0] data,
    output logic [PC_W-1:0]   pc,
    output logic              valid
);

    // A load in the same cycle as a consume refills the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= INST_W'(NOP_INST);
            pc    <= PC_W'(RESET_PC);
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : PC owner and fetch FSM; INST_FETCH_PREFETCH_EN adds a prefetch buffer
// Revision   : 1.0
// ============================================================================
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [INST_W-1:0] inst_reg,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              branch_en,
    input  logic [PC_W-1:0]   branch_target
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   squash_addr;
    logic              consume;
    logic              req_ok;
    logic              accept;
    logic              to_reg;
    logic              promote;
    logic [INST_W-1:0] buf_data;
    logic [PC_W-1:0]   buf_pc;

    assign consume = inst_valid && inst_ready;
    // Acks during SQUASH or alongside a branch belong to an abandoned address.
    assign accept  = mem_req && mem_ack && (state != SQUASH) && !branch_en;

`ifdef INST_FETCH_PREFETCH_EN
    logic buf_valid;
    logic to_buf;

    assign req_ok  = !buf_valid || inst_ready;
    assign to_reg  = accept && (!inst_valid || (consume && !buf_valid));
    assign to_buf  = accept && !to_reg;
    assign promote = consume && buf_valid && !branch_en;

    inst_fetch_buf #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (to_buf),
        .load_data (mem_rdata),
        .load_pc   (pc),
        .clear     (branch_en),
        .consume   (promote),
        .data      (buf_data),
        .pc        (buf_pc),
        .valid     (buf_valid)
    );
`else
    assign req_ok   = !inst_valid || inst_ready;
    assign to_reg   = accept;
    assign promote  = 1'b0;
    assign buf_data = '0;
    assign buf_pc   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        state_next = FETCH;
            FETCH, FULL: begin
                if (branch_en) begin
                    state_next = (mem_req && !mem_ack) ? SQUASH : FETCH;
                end else begin
                    state_next = req_ok ? FETCH : FULL;
                end
            end
            SQUASH:      if (mem_ack) state_next = FETCH;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc;
        case (state)
            FETCH, FULL: mem_req = req_ok;
            SQUASH: begin
                mem_req  = 1'b1;
                mem_addr = squash_addr;
            end
            default: ;
        endcase
    end

    // squash_addr shadows the live request address so SQUASH can keep it stable
    // while pc already holds the branch target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= PC_W'(RESET_PC);
            squash_addr <= PC_W'(RESET_PC);
            inst_reg    <= INST_W'(NOP_INST);
            inst_pc     <= PC_W'(RESET_PC);
            inst_valid  <= 1'b0;
        end else begin
            if (state != SQUASH) begin
                squash_addr <= pc;
            end
            if (branch_en) begin
                pc         <= branch_target;
                inst_valid <= 1'b0;
            end else begin
                if (accept) begin
                    pc <= pc + PC_W'(1);
                end
                if (promote) begin
                    inst_reg   <= buf_data;
                    inst_pc    <= buf_pc;
                    inst_valid <= 1'b1;
                end else if (to_reg) begin
                    inst_reg   <= mem_rdata;
                    inst_pc    <= pc;
                    inst_valid <= 1'b1;
                end else if (consume) begin
                    inst_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
